// File: rtl/data_mem_responder.sv
// Load/store responder: byte array with LATENCY wait states and valid/ready channels.
// Define DMEM_ALIGN_CHECK_EN to reject requests whose addr is not size-aligned.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          q_write;
  logic [63:0]   q_addr;
  logic [63:0]   q_wdata;
  logic [3:0]    q_size;

  logic [7:0]    mem [DEPTH];

  logic          size_ok;
  logic          range_ok;
  logic          align_ok;
  logic          err;
  logic          access;
  logic [64:0]   last;
  logic [AW-1:0] base;
  logic [63:0]   rdata;

  always_comb begin
    size_ok  = q_size inside {4'd1, 4'd2, 4'd4, 4'd8};
    // 65-bit end address so huge addresses cannot wrap into range
    last     = {1'b0, q_addr} + 65'(q_size) - 65'd1;
    range_ok = last < 65'(DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    align_ok = (q_addr[3:0] & (q_size - 4'd1)) == 4'd0;
`else
    align_ok = 1'b1;
`endif
    err      = !(size_ok && range_ok && align_ok);
    access   = (state == BUSY) && (cnt == '0);
    base     = q_addr[AW-1:0];
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(q_size))
        rdata[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  // Array has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (access && q_write && !err) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(q_size))
          mem[base + AW'(i)] <= q_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      q_write    <= 1'b0;
      q_addr     <= '0;
      q_wdata    <= '0;
      q_size     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            q_write   <= req_write;
            q_addr    <= req_addr;
            q_wdata   <= req_wdata;
            q_size    <= req_size;
            cnt       <= CW'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            resp_valid <= 1'b1;
            resp_err   <= err;
            resp_rdata <= (err || q_write) ? '0 : rdata;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
